// File: rtl/uncache_write_handler.sv
// uncache_write_handler: issues one uncached store at a time as a single-beat AXI write
module uncache_write_handler #(
    parameter int ID_W = 4,
    parameter logic [ID_W-1:0] WRITE_ID = ID_W'(1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            w,
    input  logic [31:0]     waddr,
    input  logic [31:0]     data,
    input  logic [1:0]      size,
    output logic            ready,
    output logic            bus_err,
    output logic            busy,
    output logic [ID_W-1:0] awid,
    output logic [31:0]     awaddr,
    output logic [7:0]      awlen,
    output logic [2:0]      awsize,
    output logic [1:0]      awburst,
    output logic            awvalid,
    input  logic            awready,
    output logic [31:0]     wdata,
    output logic [3:0]      wstrb,
    output logic            wlast,
    output logic            wvalid,
    input  logic            wready,
    input  logic [ID_W-1:0] bid,
    input  logic [1:0]      bresp,
    input  logic            bvalid,
    output logic            bready
);
    typedef enum logic [1:0] {IDLE, SEND, RESP} state_t;
    state_t state, state_n;
    logic aw_done, w_done, aw_hs, w_hs;
    logic [31:0] addr_q, data_q;
    logic [1:0] size_q;
    logic unused_bid;
    assign unused_bid = ^bid;
    assign aw_hs = awvalid & awready;
    assign w_hs  = wvalid & wready;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = w ? SEND : IDLE;
            SEND:    state_n = ((aw_done | aw_hs) & (w_done | w_hs)) ? RESP : SEND;
            RESP:    state_n = bvalid ? IDLE : RESP;
            default: state_n = IDLE;
        endcase
    end
    // size 2'b11 is normalised to word at latch time so awsize stays legal
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q  <= '0;
            data_q  <= '0;
            size_q  <= '0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else if (state == IDLE && w) begin
            addr_q  <= waddr;
            data_q  <= data;
            size_q  <= (size == 2'b11) ? 2'b10 : size;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            if (aw_hs) aw_done <= 1'b1;
            if (w_hs)  w_done  <= 1'b1;
        end
    end
    assign awvalid = (state == SEND) & ~aw_done;
    assign wvalid  = (state == SEND) & ~w_done;
    assign bready  = (state == RESP);
    assign ready   = bready & bvalid;
    assign bus_err = ready & (|bresp);
    assign busy    = (state != IDLE);
    assign awid    = WRITE_ID;
    assign awaddr  = addr_q;
    assign awlen   = 8'd0;
    assign awsize  = {1'b0, size_q};
    assign awburst = 2'b01;
    assign wlast   = 1'b1;
    assign wdata   = (size_q == 2'b00) ? {4{data_q[7:0]}} :
                     (size_q == 2'b01) ? {2{data_q[15:0]}} : data_q;
    assign wstrb   = (size_q == 2'b00) ? 4'b0001 << addr_q[1:0] :
                     (size_q == 2'b01) ? 4'b0011 << {addr_q[1], 1'b0} : 4'b1111;
endmodule

// File: tb/tb_uncache_write_handler.sv
// tb_uncache_write_handler: write-buffer driver, random AXI slave, queue scoreboard.
module tb_uncache_write_handler;
    logic clk = 1'b0, rst = 1'b1;
    logic w = 1'b0, ready, bus_err, busy;
    logic [31:0] waddr = '0, data = '0, awaddr, wdata;
    logic [1:0] size = '0, awburst, bresp = '0;
    logic [3:0] awid, bid = '0, wstrb;
    logic [7:0] awlen;
    logic [2:0] awsize;
    logic awvalid, awready = 1'b0, wlast, wvalid, wready = 1'b0, bvalid = 1'b0, bready;

    always #5 clk = ~clk;

    uncache_write_handler #(.ID_W(4), .WRITE_ID(4'd1)) dut (
        .clk(clk), .rst(rst), .w(w), .waddr(waddr), .data(data), .size(size),
        .ready(ready), .bus_err(bus_err), .busy(busy),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    typedef struct {logic [31:0] addr; logic [31:0] data; logic [1:0] size; logic [1:0] resp;} req_t;
    typedef struct {logic [31:0] awaddr; logic [31:0] wdata; logic [2:0] awsize; logic [3:0] wstrb; logic err;} exp_t;
    req_t wb_q[$];
    exp_t aw_q[$], w_q[$], b_q[$];
    exp_t me;
    int checks = 0, errors = 0, cyc = 0, ready_cnt = 0, ready_cyc = -1, exp_ready = 0;
    int mode = 0, hold = 0, t0, base;
    logic aw_seen = 1'b0, w_seen = 1'b0, after_ready = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(string name);
        checks++;
        errors++;
        $display("FAIL %s: got DUT activity expected none (cycle %0d)", name, cyc);
    endtask

    // Reference: lane replication by multiplication, strobes from shifted masks
    function automatic exp_t model(req_t r);
        exp_t e;
        int a = int'(r.addr % 4);
        int sz = (r.size == 2'b11) ? 2 : int'(r.size);
        e.awaddr = r.addr;
        e.awsize = 3'(sz);
        e.err = (r.resp != 2'b00);
        if (sz == 0) begin
            e.wdata = {24'b0, r.data[7:0]} * 32'h0101_0101;
            e.wstrb = 4'(1 << a);
        end else if (sz == 1) begin
            e.wdata = {16'b0, r.data[15:0]} * 32'h0001_0001;
            e.wstrb = 4'(3 << (a / 2 * 2));
        end else begin
            e.wdata = r.data;
            e.wstrb = 4'hF;
        end
        return e;
    endfunction

    task automatic push(logic [31:0] a, logic [31:0] d, logic [1:0] s, logic [1:0] rs);
        req_t r;
        exp_t e;
        r = '{a, d, s, rs};
        e = model(r);
        wb_q.push_back(r);
        aw_q.push_back(e);
        w_q.push_back(e);
        b_q.push_back(e);
        exp_ready++;
    endtask

    task automatic drive();
        w = (wb_q.size() > 0);
        if (w) begin
            waddr = wb_q[0].addr;
            data  = wb_q[0].data;
            size  = wb_q[0].size;
            bresp = wb_q[0].resp;
        end else bresp = 2'b00;
        awready = (mode == 1) ? 1'($urandom % 2) : (mode == 2) ? (hold == 0) : (mode == 3) ? 1'b0 : 1'b1;
        wready  = (mode == 1) ? 1'($urandom % 2) : 1'b1;
        bvalid  = (mode == 1) ? 1'($urandom % 2) : 1'b1;
        if (mode == 2 && busy && hold > 0) hold--;
    endtask

    // The write buffer retires its head on the edge where w & ready was seen
    task automatic step();
        logic take;
        @(negedge clk);
        take = w & ready;
        @(posedge clk);
        #1;
        if (take) void'(wb_q.pop_front());
        drive();
    endtask

    task automatic run(int budget);
        int n = 0;
        while ((wb_q.size() > 0 || b_q.size() > 0) && n < budget) begin
            step();
            n++;
        end
        if (n >= budget) begin
            checks++;
            errors++;
            $display("FAIL timeout: got %0d pending stores expected 0", b_q.size());
        end
        repeat (2) step();
    endtask

    always @(negedge clk or posedge rst) begin
        if (rst) begin
            aw_seen <= 1'b0;
            w_seen <= 1'b0;
            after_ready <= 1'b0;
        end else begin
            if (after_ready) chk("busy_after_ready", busy, 0);
            if (awvalid) begin
                if (aw_q.size() == 0) fail("aw_unexpected");
                else begin
                    me = aw_q[0];
                    chk("awaddr", awaddr, me.awaddr);
                    chk("awsize", awsize, me.awsize);
                    chk("aw_const", {awid, awlen, awburst}, {4'd1, 8'd0, 2'b01});
                    chk("aw_dup", aw_seen, 0);
                    if (awready) begin
                        void'(aw_q.pop_front());
                        aw_seen <= 1'b1;
                    end
                end
            end
            if (wvalid) begin
                if (w_q.size() == 0) fail("w_unexpected");
                else begin
                    me = w_q[0];
                    chk("wdata", wdata, me.wdata);
                    chk("wstrb", wstrb, me.wstrb);
                    chk("wlast", wlast, 1);
                    chk("w_dup", w_seen, 0);
                    if (wready) begin
                        void'(w_q.pop_front());
                        w_seen <= 1'b1;
                    end
                end
            end
            if (bready) chk("bready_early", aw_seen & w_seen, 1);
            if (ready) begin
                chk("ready_hs", bvalid & bready, 1);
                if (b_q.size() == 0) fail("ready_unexpected");
                else begin
                    me = b_q.pop_front();
                    chk("bus_err", bus_err, me.err);
                end
                aw_seen <= 1'b0;
                w_seen <= 1'b0;
                ready_cnt++;
                ready_cyc = cyc;
            end else if (bus_err) fail("bus_err_alone");
            after_ready <= ready;
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valids", {awvalid, wvalid, bready, ready, bus_err, busy}, 0);
        chk("rst_awaddr", awaddr, 0);
        chk("rst_wdata", wdata, 0);
        rst = 1'b0;
        // Word store, all readies high: ready two cycles after w
        push(32'hBFD0_03F8, 32'h1234_5678, 2'b10, 2'b00);
        step();
        t0 = cyc;
        run(50);
        chk("latency", 32'(ready_cyc - t0), 2);
        push(32'hBFAF_F003, 32'h0000_00AB, 2'b00, 2'b00);
        push(32'hBFAF_F002, 32'h0000_BEEF, 2'b01, 2'b00);
        run(50);
        // AW held off for three cycles while W completes at once
        mode = 2;
        hold = 3;
        base = ready_cnt;
        push(32'h0000_0200, 32'hCAFE_F00D, 2'b10, 2'b00);
        run(50);
        chk("skew_ready_cnt", 32'(ready_cnt - base), 1);
        mode = 0;
        base = ready_cnt;
        push(32'h0000_0100, 32'h1111_1111, 2'b10, 2'b00);
        push(32'h0000_0104, 32'h2222_2222, 2'b10, 2'b00);
        run(50);
        chk("b2b_ready_cnt", 32'(ready_cnt - base), 2);
        push(32'h0000_0300, 32'h0000_0033, 2'b00, 2'b10);
        run(50);
        // Reset while AW is stalled
        mode = 3;
        push(32'h0000_0400, 32'h4444_4444, 2'b10, 2'b00);
        repeat (3) step();
        chk("pre_rst_awvalid", awvalid, 1);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_outputs", {awvalid, wvalid, bready, busy}, 0);
        wb_q.delete();
        aw_q.delete();
        w_q.delete();
        b_q.delete();
        exp_ready--;
        w = 1'b0;
        rst = 1'b0;
        mode = 0;
        step();
        push(32'h0000_0408, 32'h5555_AAAA, 2'b01, 2'b00);
        run(50);
        mode = 1;
        for (int i = 0; i < 200; i++) begin
            push($urandom, $urandom, 2'($urandom % 4), ($urandom % 4 == 0) ? 2'($urandom % 4) : 2'b00);
            if ($urandom % 3 == 0) repeat ($urandom % 4) step();
        end
        run(20000);
        chk("ready_count", ready_cnt, exp_ready);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
